// File: rtl/conv_pkg.sv
// conv_pkg: shared types and elaboration helpers for the convolution loop controller.
package conv_pkg;

  localparam int unsigned TAG_ADDR_W = 32;

  // Controller FSM encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;

  // Per-term tag travelling alongside the operand towards the accumulator
  typedef struct packed {
    logic                  valid;
    logic                  first;
    logic                  last;
    logic [TAG_ADDR_W-1:0] out_addr;
  } tag_t;

  // Output map edge for a given input edge, kernel edge and stride
  function automatic int unsigned out_size(input int unsigned in_size, input int unsigned k,
                                           input int unsigned stride);
    return (in_size - k) / stride + 1;
  endfunction

  // Number of channel groups packed LANES-wide
  function automatic int unsigned num_groups(input int unsigned in_ch, input int unsigned lanes);
    return (in_ch + lanes - 1) / lanes;
  endfunction

  // Counter width able to hold 0..n-1
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_loop_ctrl_if.sv
// conv_loop_ctrl_if: sequencer/datapath-facing bundle of the loop controller.
// Optional macro CONV_STRIDE_EN adds the stride2 request line.
interface conv_loop_ctrl_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              start;
  logic              hold;
`ifdef CONV_STRIDE_EN
  logic              stride2;
`endif
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] ifm_addr;
  logic [ADDR_W-1:0] weight_addr;
  logic              acc_en;
  logic              acc_clr;
  logic              out_we;
  logic [ADDR_W-1:0] out_addr;

`ifdef CONV_STRIDE_EN
  modport master (output start, hold, stride2,
                  input  busy, done, rd_en, ifm_addr, weight_addr, acc_en, acc_clr, out_we, out_addr);
  modport slave  (input  start, hold, stride2,
                  output busy, done, rd_en, ifm_addr, weight_addr, acc_en, acc_clr, out_we, out_addr);
`else
  modport master (output start, hold,
                  input  busy, done, rd_en, ifm_addr, weight_addr, acc_en, acc_clr, out_we, out_addr);
  modport slave  (input  start, hold,
                  output busy, done, rd_en, ifm_addr, weight_addr, acc_en, acc_clr, out_we, out_addr);
`endif
endinterface

// File: rtl/ctrl_delay_line.sv
// ctrl_delay_line: DEPTH-stage register pipeline with synchronous clear.
module ctrl_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] pipe_q [DEPTH];
  logic [WIDTH-1:0] pipe_d [DEPTH];

  // Shift by one stage every cycle
  always_comb begin
    pipe_d[0] = d;
    for (int unsigned k = 1; k < DEPTH; k++) pipe_d[k] = pipe_q[k-1];
  end

  // Stage registers
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int unsigned k = 0; k < DEPTH; k++) pipe_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < DEPTH; k++) pipe_q[k] <= pipe_d[k];
    end
  end

  assign q = pipe_q[DEPTH-1];
endmodule

// File: rtl/conv_loop_ctrl.sv
// conv_loop_ctrl: self-sequencing m/r/c/ng/i/j loop nest issuing one MAC term per cycle.
// Optional macro CONV_STRIDE_EN adds a per-layer stride-2 mode.
module conv_loop_ctrl
  import conv_pkg::*;
#(
  parameter int unsigned K        = 5,
  parameter int unsigned IN_SIZE  = 32,
  parameter int unsigned IN_CH    = 1,
  parameter int unsigned OUT_CH   = 6,
  parameter int unsigned LANES    = 4,
  parameter int unsigned PIPE_LAT = 2,
  parameter int unsigned ADDR_W   = 16
) (
  input logic             clock,
  input logic             reset,
  conv_loop_ctrl_if.slave bus
);
  localparam int unsigned OUT_SIZE    = out_size(IN_SIZE, K, 1);
  localparam int unsigned OUT_SIZE_S2 = out_size(IN_SIZE, K, 2);
  localparam int unsigned NG          = num_groups(IN_CH, LANES);
  localparam int unsigned K_W         = cnt_w(K);
  localparam int unsigned E_W         = cnt_w(OUT_SIZE);
  localparam int unsigned G_W         = cnt_w(NG);
  localparam int unsigned M_W         = cnt_w(OUT_CH);
  localparam int unsigned D_W         = cnt_w(PIPE_LAT + 2);
  localparam int unsigned TAG_W       = $bits(tag_t);
  localparam longint unsigned ADDR_SPAN = 64'd1 << ADDR_W;

  // Address spaces must fit the configured address width
  if ((64'(OUT_CH) * NG * K * K > ADDR_SPAN) || (64'(NG) * IN_SIZE * IN_SIZE > ADDR_SPAN))
  begin : g_addr_chk
    $error("conv_loop_ctrl: address space exceeds ADDR_W");
  end

  state_t            state_q, state_d;
  logic [M_W-1:0]    m_q, m_d;
  logic [E_W-1:0]    r_q, r_d, c_q, c_d;
  logic [G_W-1:0]    g_q, g_d;
  logic [K_W-1:0]    i_q, i_d, j_q, j_d;
  logic [D_W-1:0]    drain_q, drain_d;
  logic              busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d;
  logic              out_we_q, out_we_d;
  logic [ADDR_W-1:0] ifm_addr_q, ifm_addr_d, weight_addr_q, weight_addr_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  tag_t              tag_q, tag_d, dly_q;
  logic              stride_c;

`ifdef CONV_STRIDE_EN
  logic stride_q, stride_d;
  assign stride_c = stride_q;
`else
  assign stride_c = 1'b0;
`endif

  logic [E_W-1:0] edge_c;
  logic [31:0]    area_c, row_c, col_c, ifm_full_c, wgt_full_c, pix_full_c;
  logic           j_wrap, i_wrap, g_wrap, c_wrap, r_wrap, m_wrap, pix_done, last_term;

  // Full-width address arithmetic and loop-wrap decode for the current term
  always_comb begin
    edge_c     = stride_c ? E_W'(OUT_SIZE_S2) : E_W'(OUT_SIZE);
    area_c     = stride_c ? 32'(OUT_SIZE_S2 * OUT_SIZE_S2) : 32'(OUT_SIZE * OUT_SIZE);
    row_c      = stride_c ? (32'(r_q) << 1) + 32'(i_q) : 32'(r_q) + 32'(i_q);
    col_c      = stride_c ? (32'(c_q) << 1) + 32'(j_q) : 32'(c_q) + 32'(j_q);
    ifm_full_c = 32'(g_q) * (IN_SIZE * IN_SIZE) + row_c * IN_SIZE + col_c;
    wgt_full_c = 32'(m_q) * (NG * K * K) + 32'(g_q) * (K * K) + 32'(i_q) * K + 32'(j_q);
    pix_full_c = 32'(m_q) * area_c + 32'(r_q) * 32'(edge_c) + 32'(c_q);
    j_wrap     = (j_q == K_W'(K - 1));
    i_wrap     = (i_q == K_W'(K - 1));
    g_wrap     = (g_q == G_W'(NG - 1));
    c_wrap     = (c_q == edge_c - E_W'(1));
    r_wrap     = (r_q == edge_c - E_W'(1));
    m_wrap     = (m_q == M_W'(OUT_CH - 1));
    pix_done   = j_wrap & i_wrap & g_wrap;
    last_term  = pix_done & c_wrap & r_wrap & m_wrap;
  end

  // Next-state: FSM, loop nest advance and term issue
  always_comb begin
    state_d       = state_q;
    m_d           = m_q;
    r_d           = r_q;
    c_d           = c_q;
    g_d           = g_q;
    i_d           = i_q;
    j_d           = j_q;
    drain_d       = drain_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    rd_en_d       = 1'b0;
    ifm_addr_d    = ifm_addr_q;
    weight_addr_d = weight_addr_q;
    tag_d         = '0;
`ifdef CONV_STRIDE_EN
    stride_d      = stride_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          busy_d  = 1'b1;
          m_d     = '0;
          r_d     = '0;
          c_d     = '0;
          g_d     = '0;
          i_d     = '0;
          j_d     = '0;
`ifdef CONV_STRIDE_EN
          stride_d = bus.stride2;
`endif
        end
      end
      ST_RUN: begin
        if (!bus.hold) begin
          rd_en_d        = 1'b1;
          ifm_addr_d     = ADDR_W'(ifm_full_c);
          weight_addr_d  = ADDR_W'(wgt_full_c);
          tag_d.valid    = 1'b1;
          tag_d.first    = (g_q == '0) && (i_q == '0) && (j_q == '0);
          tag_d.last     = pix_done;
          tag_d.out_addr = pix_full_c;
          j_d = j_wrap ? '0 : j_q + K_W'(1);
          if (j_wrap)                     i_d = i_wrap ? '0 : i_q + K_W'(1);
          if (j_wrap && i_wrap)           g_d = g_wrap ? '0 : g_q + G_W'(1);
          if (pix_done)                   c_d = c_wrap ? '0 : c_q + E_W'(1);
          if (pix_done && c_wrap)         r_d = r_wrap ? '0 : r_q + E_W'(1);
          if (pix_done && c_wrap && r_wrap) m_d = m_wrap ? '0 : m_q + M_W'(1);
          if (last_term) begin
            state_d = ST_DRAIN;
            drain_d = '0;
          end
        end
      end
      ST_DRAIN: begin
        // Last tag reaches the accumulator PIPE_LAT+1 cycles after issue; out_we one later
        drain_d = drain_q + D_W'(1);
        if (drain_q == D_W'(PIPE_LAT + 1)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Accumulator-side tags
  ctrl_delay_line #(
    .WIDTH (TAG_W),
    .DEPTH (PIPE_LAT)
  ) u_dly (
    .clk   (clock),
    .clear (reset),
    .d     (tag_q),
    .q     (dly_q)
  );

  // Output-buffer write strobe and address
  always_comb begin
    out_we_d   = dly_q.valid & dly_q.last;
    out_addr_d = out_we_d ? ADDR_W'(dly_q.out_addr) : out_addr_q;
  end

  // State registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      m_q           <= '0;
      r_q           <= '0;
      c_q           <= '0;
      g_q           <= '0;
      i_q           <= '0;
      j_q           <= '0;
      drain_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rd_en_q       <= 1'b0;
      ifm_addr_q    <= '0;
      weight_addr_q <= '0;
      tag_q         <= '0;
      out_we_q      <= 1'b0;
      out_addr_q    <= '0;
`ifdef CONV_STRIDE_EN
      stride_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      m_q           <= m_d;
      r_q           <= r_d;
      c_q           <= c_d;
      g_q           <= g_d;
      i_q           <= i_d;
      j_q           <= j_d;
      drain_q       <= drain_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      rd_en_q       <= rd_en_d;
      ifm_addr_q    <= ifm_addr_d;
      weight_addr_q <= weight_addr_d;
      tag_q         <= tag_d;
      out_we_q      <= out_we_d;
      out_addr_q    <= out_addr_d;
`ifdef CONV_STRIDE_EN
      stride_q      <= stride_d;
`endif
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.rd_en       = rd_en_q;
  assign bus.ifm_addr    = ifm_addr_q;
  assign bus.weight_addr = weight_addr_q;
  assign bus.acc_en      = dly_q.valid;
  assign bus.acc_clr     = dly_q.valid & dly_q.first;
  assign bus.out_we      = out_we_q;
  assign bus.out_addr    = out_addr_q;
endmodule

// File: tb/tb_conv_loop_ctrl.sv
// tb_conv_loop_ctrl: several configurations of conv_loop_ctrl checked against an
// arithmetic loop-nest model plus a table of fixed expected terms/writes.
module tb_conv_loop_ctrl;
`ifdef CONV_STRIDE_EN
  localparam int N_DUT = 4;
`else
  localparam int N_DUT = 3;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic start_r = 1'b0, hold_r = 1'b0, stride_r = 1'b0;
  int   sel = 0;
  bit   cur_stride = 1'b0;

  // Configurations: 0 default, 1 small full-run, 2 IN_CH=8, 3 stride K=4
  int cfg_k   [4] = '{5, 3, 5, 4};
  int cfg_in  [4] = '{32, 8, 32, 32};
  int cfg_ng  [4] = '{1, 2, 2, 1};
  int cfg_m   [4] = '{6, 2, 6, 6};
  int cfg_lat [4] = '{2, 3, 2, 2};

  conv_loop_ctrl_if #(.ADDR_W(16)) if_a ();
  conv_loop_ctrl_if #(.ADDR_W(16)) if_b ();
  conv_loop_ctrl_if #(.ADDR_W(16)) if_c ();
  assign if_a.start = start_r && (sel == 0);
  assign if_b.start = start_r && (sel == 1);
  assign if_c.start = start_r && (sel == 2);
  assign if_a.hold  = hold_r;
  assign if_b.hold  = hold_r;
  assign if_c.hold  = hold_r;
`ifdef CONV_STRIDE_EN
  conv_loop_ctrl_if #(.ADDR_W(16)) if_d ();
  assign if_d.start   = start_r && (sel == 3);
  assign if_d.hold    = hold_r;
  assign if_a.stride2 = stride_r;
  assign if_b.stride2 = stride_r;
  assign if_c.stride2 = stride_r;
  assign if_d.stride2 = stride_r;
  conv_loop_ctrl #(.K(4)) u_d (.clock(clk), .reset(rst), .bus(if_d));
`endif

  conv_loop_ctrl u_a (.clock(clk), .reset(rst), .bus(if_a));
  conv_loop_ctrl #(.K(3), .IN_SIZE(8), .IN_CH(8), .LANES(4), .OUT_CH(2), .PIPE_LAT(3), .ADDR_W(16))
    u_b (.clock(clk), .reset(rst), .bus(if_b));
  conv_loop_ctrl #(.IN_CH(8)) u_c (.clock(clk), .reset(rst), .bus(if_c));

  typedef struct packed {
    logic busy, done, rd_en, acc_en, acc_clr, out_we;
    logic [15:0] ifm, wgt, oa;
  } mon_t;
  mon_t mon_a, mon_b, mon_c, mon_d, mon;
  assign mon_a = {if_a.busy, if_a.done, if_a.rd_en, if_a.acc_en, if_a.acc_clr, if_a.out_we,
                  if_a.ifm_addr, if_a.weight_addr, if_a.out_addr};
  assign mon_b = {if_b.busy, if_b.done, if_b.rd_en, if_b.acc_en, if_b.acc_clr, if_b.out_we,
                  if_b.ifm_addr, if_b.weight_addr, if_b.out_addr};
  assign mon_c = {if_c.busy, if_c.done, if_c.rd_en, if_c.acc_en, if_c.acc_clr, if_c.out_we,
                  if_c.ifm_addr, if_c.weight_addr, if_c.out_addr};
`ifdef CONV_STRIDE_EN
  assign mon_d = {if_d.busy, if_d.done, if_d.rd_en, if_d.acc_en, if_d.acc_clr, if_d.out_we,
                  if_d.ifm_addr, if_d.weight_addr, if_d.out_addr};
`else
  assign mon_d = '0;
`endif
  always_comb begin
    case (sel)
      0:       mon = mon_a;
      1:       mon = mon_b;
      2:       mon = mon_c;
      default: mon = mon_d;
    endcase
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Captured events for the fixed-value table
  int log_ifm [4][64];
  int log_wgt [4][64];
  int log_oa  [4][4];
  int log_ocy [4][4];
  int exp_last_ifm [4];
  int exp_last_wgt [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int edge_of(input int s);
    return cur_stride ? (cfg_in[s] - cfg_k[s]) / 2 + 1 : cfg_in[s] - cfg_k[s] + 1;
  endfunction

  function automatic int terms_of(input int s);
    int e = edge_of(s);
    return cfg_m[s] * e * e * cfg_ng[s] * cfg_k[s] * cfg_k[s];
  endfunction

  // Decompose flat term index t into the loop indices and derive all addresses
  task automatic model(input int s, input int t, output int ifm, output int wgt,
                       output int pix, output bit first, output bit last);
    int k, kk, per_pix, e, st, j, i, g, c, r, m;
    k = cfg_k[s]; kk = k * k; per_pix = kk * cfg_ng[s]; e = edge_of(s);
    st = cur_stride ? 2 : 1;
    j = t % k; i = (t / k) % k; g = (t / kk) % cfg_ng[s];
    pix = t / per_pix; c = pix % e; r = (pix / e) % e; m = pix / (e * e);
    ifm   = g * cfg_in[s] * cfg_in[s] + (st * r + i) * cfg_in[s] + (st * c + j);
    wgt   = m * cfg_ng[s] * kk + g * kk + i * k + j;
    first = (t % per_pix) == 0;
    last  = (t % per_pix) == per_pix - 1;
  endtask

  task automatic check_idle(input string name);
    check({name, " flags"}, 64'({mon.busy, mon.done, mon.rd_en, mon.acc_en, mon.acc_clr, mon.out_we}), 64'd0);
    check({name, " addrs"}, 64'({mon.ifm, mon.wgt, mon.oa}), 64'd0);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst = 1'b1; start_r = 1'b0; hold_r = 1'b0;
    @(posedge clk); #1;
    check_idle(name);
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      exp_last_ifm[s] = 0;
      exp_last_wgt[s] = 0;
    end
  endtask

  // Start a layer on DUT s and follow it for up to max_cyc edges
  task automatic run_layer(input int s, input int hold_pct, input int max_cyc,
                           input bit expect_done, input int busy_start_at);
    int ni, na, no, holds, t_total, per_pix, lat, e_ifm, e_wgt, e_pix;
    bit e_first, e_last, done_seen;
    ni = 0; na = 0; no = 0; holds = 0; done_seen = 0;
    sel = s; lat = cfg_lat[s];
    t_total = terms_of(s);
    per_pix = cfg_k[s] * cfg_k[s] * cfg_ng[s];
    @(negedge clk);
    start_r = 1'b1;
    hold_r  = (hold_pct > 0);
    @(posedge clk); #1;
    check("busy after start", 64'(mon.busy), 64'd1);
    for (int n = 1; n <= max_cyc; n++) begin
      @(negedge clk);
      start_r = (n == busy_start_at);
      hold_r  = ($urandom_range(0, 99) < hold_pct);
      if (hold_r && ni < t_total) holds++;
      @(posedge clk); #1;
      if (ni < t_total) check(hold_r ? "no issue on hold" : "issue when free", 64'(mon.rd_en), 64'(!hold_r));
      if (mon.rd_en) begin
        model(s, ni, e_ifm, e_wgt, e_pix, e_first, e_last);
        check("ifm_addr", 64'(mon.ifm), 64'(16'(e_ifm)));
        check("weight_addr", 64'(mon.wgt), 64'(16'(e_wgt)));
        if (hold_pct == 0) check("issue cycle", 64'(n), 64'(1 + ni));
        if (ni < 64) begin
          log_ifm[s][ni] = mon.ifm;
          log_wgt[s][ni] = mon.wgt;
        end
        exp_last_ifm[s] = e_ifm;
        exp_last_wgt[s] = e_wgt;
        ni++;
      end else begin
        check("ifm_addr retained", 64'(mon.ifm), 64'(16'(exp_last_ifm[s])));
        check("weight_addr retained", 64'(mon.wgt), 64'(16'(exp_last_wgt[s])));
      end
      if (mon.acc_en) begin
        model(s, na, e_ifm, e_wgt, e_pix, e_first, e_last);
        check("acc_clr", 64'(mon.acc_clr), 64'(e_first));
        if (hold_pct == 0) check("acc_en cycle", 64'(n), 64'(1 + na + lat));
        na++;
      end else begin
        check("acc_clr without acc_en", 64'(mon.acc_clr), 64'd0);
      end
      if (mon.out_we) begin
        check("out_addr", 64'(mon.oa), 64'(16'(no)));
        if (hold_pct == 0) check("out_we cycle", 64'(n), 64'((no + 1) * per_pix + lat + 1));
        if (no < 4) begin
          log_oa[s][no]  = mon.oa;
          log_ocy[s][no] = n;
        end
        no++;
      end
      if (mon.done) begin
        check("done cycle", 64'(n), 64'(t_total + lat + 2 + holds));
        check("busy low with done", 64'(mon.busy), 64'd0);
        check("terms issued", 64'(ni), 64'(t_total));
        check("acc terms", 64'(na), 64'(t_total));
        check("pixels written", 64'(no), 64'(t_total / per_pix));
        done_seen = 1'b1;
        break;
      end
    end
    start_r = 1'b0;
    hold_r  = 1'b0;
    if (expect_done && !done_seen) check("done within budget", 64'd0, 64'd1);
    if (expect_done && done_seen) begin
      @(posedge clk); #1;
      check("done single pulse", 64'(mon.done), 64'd0);
    end
  endtask

  typedef struct {
    int s;
    int kind;   // 0: issued term {ifm, weight}, 1: output write {out_addr, cycle}
    int idx;
    int exp_a;
    int exp_b;
  } vec_t;

  initial begin
    vec_t vecs[$];
    bit   quiet;
    vecs.push_back('{0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 5, 32, 5});
    vecs.push_back('{0, 0, 24, 132, 24});
    vecs.push_back('{0, 0, 25, 1, 0});
    vecs.push_back('{0, 1, 0, 0, 28});
    vecs.push_back('{0, 1, 1, 1, 53});
    vecs.push_back('{2, 0, 25, 1024, 25});
    vecs.push_back('{2, 0, 49, 1156, 49});
    vecs.push_back('{2, 0, 50, 1, 0});
    vecs.push_back('{2, 1, 0, 0, 53});
`ifdef CONV_STRIDE_EN
    vecs.push_back('{3, 0, 15, 99, 15});
    vecs.push_back('{3, 0, 16, 2, 0});
    vecs.push_back('{3, 1, 1, 1, 35});
`endif
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 64; k++) begin
        log_ifm[s][k] = -1;
        log_wgt[s][k] = -1;
      end
      for (int k = 0; k < 4; k++) begin
        log_oa[s][k]  = -1;
        log_ocy[s][k] = -1;
      end
    end

    // Default layer: partial run with a start while busy, then mid-run reset
    sel = 0;
    do_reset("reset values");
    run_layer(0, 0, 40, 1'b0, 20);
    check("still busy mid-run", 64'(mon.busy), 64'd1);
    do_reset("mid-run reset");
    quiet = 1'b1;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (mon.rd_en || mon.acc_en || mon.out_we || mon.busy) quiet = 1'b0;
    end
    check("quiet after reset", 64'(quiet), 64'd1);
    run_layer(0, 0, 60, 1'b0, 0);

    // Two channel groups
    do_reset("reset before IN_CH=8");
    run_layer(2, 0, 60, 1'b0, 0);

    // Small layer to completion, then with random hold back-pressure
    do_reset("reset before small layer");
    run_layer(1, 0, 1400, 1'b1, 0);
    run_layer(1, 30, 4000, 1'b1, 0);

`ifdef CONV_STRIDE_EN
    do_reset("reset before stride");
    cur_stride = 1'b1;
    stride_r   = 1'b1;
    run_layer(3, 0, 40, 1'b0, 0);
    stride_r   = 1'b0;
    cur_stride = 1'b0;
`endif

    foreach (vecs[v]) begin
      if (vecs[v].kind == 0) begin
        check($sformatf("table ifm cfg%0d term%0d", vecs[v].s, vecs[v].idx),
              64'(log_ifm[vecs[v].s][vecs[v].idx]), 64'(vecs[v].exp_a));
        check($sformatf("table weight cfg%0d term%0d", vecs[v].s, vecs[v].idx),
              64'(log_wgt[vecs[v].s][vecs[v].idx]), 64'(vecs[v].exp_b));
      end else begin
        check($sformatf("table out_addr cfg%0d write%0d", vecs[v].s, vecs[v].idx),
              64'(log_oa[vecs[v].s][vecs[v].idx]), 64'(vecs[v].exp_a));
        check($sformatf("table out_we cycle cfg%0d write%0d", vecs[v].s, vecs[v].idx),
              64'(log_ocy[vecs[v].s][vecs[v].idx]), 64'(vecs[v].exp_b));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/conv_loop_ctrl.md
# conv_loop_ctrl

Self-sequencing loop controller for the convolution datapath. It owns the full output-channel / row / column / channel-group / kernel iteration nest. Per issued MAC term it drives input-feature-map and weight buffer addresses, plus delay-aligned accumulator controls and output-buffer write strobes. It sits between the layer-level start/done sequencer and the buffers, PE lanes and accumulators, and replaces externally driven iterators and fixed layer sizes with parameters and a start/done handshake.

## Interface
- K, 5, kernel edge (K×K window)
- IN_SIZE, 32, input map edge; OUT_SIZE = IN_SIZE−K+1 (derived localparam, 28 by default)
- IN_CH, 1, input channels
- OUT_CH, 6, output channels
- LANES, 4, channels packed per ifm word; NG = ceil(IN_CH/LANES) channel groups
- PIPE_LAT, 2, cycles from address issue to operand at accumulator (buffer read + PE register)
- ADDR_W, 16, width of all address outputs
- clock  in  1  sole clock, all state on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin layer; sampled only in IDLE
- hold  in  1  freeze iteration this cycle (downstream back-pressure)
- busy  out  1  high from start acceptance until done
- done  out  1  single-cycle pulse at layer completion
- rd_en  out  1  ifm/weight read enable; high on cycles a term is issued
- ifm_addr  out  ADDR_W  ng·IN_SIZE² + (r+i)·IN_SIZE + (c+j)
- weight_addr  out  ADDR_W  m·NG·K² + ng·K² + i·K + j
- acc_en  out  1  operand valid at accumulator
- acc_clr  out  1  with acc_en: first term of a pixel (load, not add)
- out_we  out  1  write finished pixel to output buffer
- out_addr  out  ADDR_W  m·OUT_SIZE² + r·OUT_SIZE + c, valid with out_we

## Operation
- States: IDLE → RUN (start=1) → DRAIN (last term issued) → IDLE (after done).
- Loop nest, outer to inner: m [0,OUT_CH), r [0,OUT_SIZE), c [0,OUT_SIZE), ng [0,NG), i [0,K), j [0,K). j wraps first, and each wrap carries into the next index outward.
- RUN with hold=0: issue one term per cycle (rd_en=1, addresses registered), then advance the nest. With hold=1: no issue, rd_en=0, counters frozen, addresses keep their last value.
- Each issued term carries tags {first, last, out_addr} down a PIPE_LAT-deep delay line. A bubble (valid=0) is inserted on non-issue cycles. The delay line shifts every cycle regardless of hold.
- acc_en = delayed valid; acc_clr = delayed valid & first; out_we = registered (delayed valid & last), out_addr registered alongside.
- DRAIN: no issue. Wait until the delay line empties and the final out_we has fired, then pulse done and drop busy in the same cycle.
- start while busy: ignored. start and hold both high in IDLE: start accepted, and the first issue waits for hold=0.
- Address arithmetic in full width, then truncated to ADDR_W. The elaboration check fails if OUT_CH·NG·K² or NG·IN_SIZE² exceeds 2^ADDR_W.
- Reset at any time: state IDLE, counters 0, delay line cleared, so no stray acc_en/out_we after reset.

## Timing
- Reset values: busy, done, rd_en, acc_en, acc_clr, out_we = 0; ifm_addr, weight_addr, out_addr = 0.
- start sampled high at edge E0 → busy=1 after E0. With no hold, term t issues at edge E(1+t).
- acc_en for term t rises after E(1+t+PIPE_LAT); out_we for a pixel follows its last acc_en by one cycle.
- Total terms T = OUT_CH·OUT_SIZE²·NG·K². done pulses one cycle after the final out_we, i.e. after E(T+PIPE_LAT+2) when there are no holds.

## Configuration
- CONV_STRIDE_EN defined: adds input port stride2 (1 bit, sampled at start acceptance, held for the layer).
  - With stride2=1: output edge = (IN_SIZE−K)/2+1, and ifm_addr uses row 2r+i, column 2c+j.
  - out_addr uses the reduced edge.
- Undefined: no port, stride fixed at 1, formulas as above.

## Structure
- Package conv_pkg: state enum (IDLE/RUN/DRAIN), tag struct {valid, first, last, out_addr}, derived localparam functions (OUT_SIZE, NG, clog2 widths).
- Sub-module ctrl_delay_line: parametrised WIDTH/DEPTH register pipeline with synchronous clear. It carries the tag struct.

## Test plan
- Defaults, start pulse, no hold → first rd_en after E1 with ifm_addr=0, weight_addr=0. Term 5: ifm_addr=32, weight_addr=5. First out_we after E28 with out_addr=0. done after E117604 (T=117600).
- Pixel boundary: acc_clr with terms 0 and 25 only. Second out_we has out_addr=1 and occurs 25 cycles after the first.
- IN_CH=8 (NG=2): term 25 gives ifm_addr=1024, weight_addr=25. Term 50 (m=0, r=0, c=1, ng=0, i=0, j=0) gives ifm_addr=1, weight_addr=0. One out_we per 50 terms.
- Random hold (30%) → identical sequences of addresses, acc_en and out_addr compared against the no-hold run. done is delayed by exactly the number of hold cycles during RUN.
- Reset asserted mid-RUN, plus start while busy → all outputs 0 next cycle, no later acc_en/out_we. The busy-time start has no effect. A fresh start reproduces the first scenario.
- CONV_STRIDE_EN, stride2=1, IN_SIZE=32, K=4 → output edge 15. Pixel (0,1) first term ifm_addr=2, and its out_we carries out_addr=1.
